// File: rtl/map_uxrom_gen_pkg.sv
// Shared mapper definitions: bank-mode codes, save-state indices and the
// PRG bank selection helper used by the discrete-logic mappers.
package map_uxrom_gen_pkg;

    localparam int MODE_UNROM = 0;
    localparam int MODE_180   = 1;
    localparam int MODE_32K   = 2;

    localparam logic [7:0] SS_IDX_PRG   = 8'd0;
    localparam logic [7:0] SS_IDX_CHR   = 8'd1;
    localparam logic [7:0] SS_IDX_FLAGS = 8'd2;
    localparam logic [7:0] SS_IDX_ID    = 8'd127;

    localparam logic [7:0] SS_ID_180   = 8'd180;
    localparam logic [7:0] SS_ID_UNROM = 8'd2;
    localparam logic [7:0] SS_RD_NONE  = 8'hFF;

    // 16 KB bank number for the current CPU access; a14 picks the $C000 half.
    function automatic logic [7:0] bank_sel(input int mode, input logic [7:0] prg,
                                            input logic [7:0] last_bank, input logic a14);
        logic [7:0] bank;
        case (mode)
            MODE_UNROM: bank = a14 ? last_bank : prg;
            MODE_180:   bank = a14 ? prg : 8'h00;
            MODE_32K:   bank = {prg[6:0], a14};
            default:    bank = prg;
        endcase
        return bank;
    endfunction

endpackage

// File: rtl/map_uxrom_gen.sv
// Generic UxROM-family mapper: PRG/CHR bank latch with optional bus conflicts,
// read-modify-write filtering, single-screen mirroring and save-state access.
module map_uxrom_gen
    import map_uxrom_gen_pkg::*;
#(
    parameter int PRG_BITS  = 4,
    parameter int CHR_BITS  = 0,
    parameter int CHR_SHIFT = 4,
    parameter int MODE      = 0,
    parameter int BUS_CONF  = 1,
    parameter int RMW_FILT  = 1,
    parameter int MIR_BIT   = 8
) (
    input  logic        m2,
    input  logic        map_rst,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    input  logic [7:0]  prg_dat,
    input  logic        cpu_ce,
    input  logic        cpu_rw,
    input  logic [13:0] ppu_addr,
    input  logic        cfg_mir_v,
    input  logic        ss_act,
    input  logic        ss_we,
    input  logic [7:0]  ss_addr,
    output logic [21:0] prg_addr,
    output logic [16:0] chr_addr,
    output logic        ciram_a10,
    output logic        ciram_ce,
    output logic [7:0]  ss_rdat
);

    localparam int         CHR_W     = (CHR_BITS > 0) ? CHR_BITS : 1;
    localparam logic [7:0] LAST_BANK = 8'((1 << PRG_BITS) - 1);

    logic [PRG_BITS-1:0] prg_r;
    logic [CHR_W-1:0]    chr_r;
    logic                mir_r;
    logic                wr_last_r;

    logic [7:0]       eff_s;
    logic             cpu_wr_s;
    logic             accept_s;
    logic [CHR_W-1:0] chr_new_s;
    logic [CHR_W-1:0] chr_eff_s;
    logic             mir_new_s;
    logic [7:0]       bank_s;
    logic             unused_bits_s;

    assign cpu_wr_s      = !cpu_ce && !cpu_rw;
    assign eff_s         = (BUS_CONF != 0) ? (cpu_dat & prg_dat) : cpu_dat;
    assign accept_s      = cpu_wr_s && !ss_act && !((RMW_FILT != 0) && wr_last_r);
    assign unused_bits_s = ^{eff_s, prg_dat};

    generate
        if (CHR_BITS > 0) begin : g_chr
            assign chr_new_s = eff_s[CHR_SHIFT +: CHR_BITS];
            assign chr_eff_s = chr_r;
        end else begin : g_no_chr
            assign chr_new_s = {CHR_W{1'b0}};
            assign chr_eff_s = {CHR_W{1'b0}};
        end
        if (MIR_BIT < 8) begin : g_mir
            assign mir_new_s = eff_s[MIR_BIT];
        end else begin : g_no_mir
            assign mir_new_s = mir_r;
        end
    endgenerate

    // Bank latch on the m2 fall; save-state access owns the registers while active.
    always_ff @(negedge m2 or posedge map_rst) begin
        if (map_rst) begin
            prg_r     <= {PRG_BITS{1'b0}};
            chr_r     <= {CHR_W{1'b0}};
            mir_r     <= 1'b0;
            wr_last_r <= 1'b0;
        end else if (ss_act) begin
            if (ss_we) begin
                case (ss_addr)
                    SS_IDX_PRG:   prg_r <= cpu_dat[PRG_BITS-1:0];
                    SS_IDX_CHR:   chr_r <= cpu_dat[CHR_W-1:0];
                    SS_IDX_FLAGS: {wr_last_r, mir_r} <= cpu_dat[1:0];
                    default:      prg_r <= prg_r;
                endcase
            end
        end else begin
            // Filtered writes still mark the cycle, so a write chain keeps only its first.
            wr_last_r <= cpu_wr_s;
            if (accept_s) begin
                prg_r <= eff_s[PRG_BITS-1:0];
                chr_r <= chr_new_s;
                mir_r <= mir_new_s;
            end
        end
    end

    assign bank_s    = bank_sel(MODE, 8'(prg_r), LAST_BANK, cpu_addr[14]);
    assign prg_addr  = {bank_s, cpu_addr[13:0]};
    assign chr_addr  = {4'(chr_eff_s), ppu_addr[12:0]};
    assign ciram_ce  = !ppu_addr[13];
    assign ciram_a10 = (MIR_BIT < 8) ? mir_r : (cfg_mir_v ? ppu_addr[10] : ppu_addr[11]);

    // Save-state readback mux, combinational so it can be read without an m2 edge.
    always_comb begin
        ss_rdat = SS_RD_NONE;
        case (ss_addr)
            SS_IDX_PRG:   ss_rdat = 8'(prg_r);
            SS_IDX_CHR:   ss_rdat = 8'(chr_eff_s);
            SS_IDX_FLAGS: ss_rdat = {6'b000000, wr_last_r, mir_r};
            SS_IDX_ID:    ss_rdat = (MODE == MODE_180) ? SS_ID_180 : SS_ID_UNROM;
            default:      ss_rdat = SS_RD_NONE;
        endcase
    end

endmodule

// File: tb/tb_map_uxrom_gen.sv
// Self-checking bench for map_uxrom_gen: three configurations share one stimulus
// bus; expectations are queued as stimulus is applied and checked after settling.
module tb_map_uxrom_gen;

    logic        m2 = 1'b0;
    logic        map_rst;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_dat, prg_dat;
    logic        cpu_ce, cpu_rw;
    logic [13:0] ppu_addr;
    logic        cfg_mir_v, ss_act, ss_we;
    logic [7:0]  ss_addr;

    logic [21:0] pa0, pa1, pa2;
    logic [16:0] ca0, ca1, ca2;
    logic        a10_0, a10_1, a10_2, ce0, ce1, ce2;
    logic [7:0]  rd0, rd1, rd2;

    // u0: MODE 0, 3-bit PRG, 2-bit CHR at bit 4, mirroring from bit 7, no bus conflict
    map_uxrom_gen #(.PRG_BITS(3), .CHR_BITS(2), .CHR_SHIFT(4), .MODE(0), .BUS_CONF(0),
                    .RMW_FILT(1), .MIR_BIT(7)) u0 (
        .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .prg_dat(prg_dat),
        .cpu_ce(cpu_ce), .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .cfg_mir_v(cfg_mir_v),
        .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .prg_addr(pa0), .chr_addr(ca0),
        .ciram_a10(a10_0), .ciram_ce(ce0), .ss_rdat(rd0));

    // u1: MODE 1 with bus conflicts, no CHR banking, hardware mirroring
    map_uxrom_gen #(.PRG_BITS(4), .CHR_BITS(0), .CHR_SHIFT(4), .MODE(1), .BUS_CONF(1),
                    .RMW_FILT(1), .MIR_BIT(8)) u1 (
        .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .prg_dat(prg_dat),
        .cpu_ce(cpu_ce), .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .cfg_mir_v(cfg_mir_v),
        .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .prg_addr(pa1), .chr_addr(ca1),
        .ciram_a10(a10_1), .ciram_ce(ce1), .ss_rdat(rd1));

    // u2: MODE 2 (32 KB), bus conflicts, 1-bit CHR, no write filter
    map_uxrom_gen #(.PRG_BITS(4), .CHR_BITS(1), .CHR_SHIFT(4), .MODE(2), .BUS_CONF(1),
                    .RMW_FILT(0), .MIR_BIT(8)) u2 (
        .m2(m2), .map_rst(map_rst), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat), .prg_dat(prg_dat),
        .cpu_ce(cpu_ce), .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .cfg_mir_v(cfg_mir_v),
        .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .prg_addr(pa2), .chr_addr(ca2),
        .ciram_a10(a10_2), .ciram_ce(ce2), .ss_rdat(rd2));

    always #10 m2 = ~m2;

    localparam int P0 = 0, P1 = 1, P2 = 2, C0 = 3, C1 = 4, C2 = 5, A0 = 6, A1 = 7, A2 = 8;
    localparam int E0 = 9, E1 = 10, E2 = 11, S0 = 12, S1 = 13, S2 = 14;

    typedef struct {
        string       name;
        int          sel;
        logic [23:0] exp;
    } chk_t;

    typedef struct {
        logic [7:0]  dat;
        logic [7:0]  pdat;
        logic [14:0] raddr;
        logic [21:0] e0;
        logic [21:0] e1;
        logic [21:0] e2;
    } vec_t;

    chk_t sb_q[$];
    vec_t vecs[7];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [23:0] actual(input int sel);
        case (sel)
            P0: return 24'(pa0);
            P1: return 24'(pa1);
            P2: return 24'(pa2);
            C0: return 24'(ca0);
            C1: return 24'(ca1);
            C2: return 24'(ca2);
            A0: return 24'(a10_0);
            A1: return 24'(a10_1);
            A2: return 24'(a10_2);
            E0: return 24'(ce0);
            E1: return 24'(ce1);
            E2: return 24'(ce2);
            S0: return 24'(rd0);
            S1: return 24'(rd1);
            S2: return 24'(rd2);
            default: return 24'hDEAD;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [23:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sb_q.push_back(c);
    endtask

    task automatic check_all();
        chk_t c;
        #1;
        while (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            total++;
            if (actual(c.sel) !== c.exp) begin
                bad++;
                $display("FAIL %s: got %0h expected %0h", c.name, actual(c.sel), c.exp);
            end
        end
    endtask

    task automatic tick();
        @(negedge m2);
        #2;
    endtask

    task automatic idle();
        cpu_ce = 1'b1;
        cpu_rw = 1'b1;
        ss_act = 1'b0;
        ss_we  = 1'b0;
        tick();
    endtask

    task automatic cpu_write(input logic [7:0] d, input logic [7:0] p);
        cpu_ce  = 1'b0;
        cpu_rw  = 1'b0;
        cpu_dat = d;
        prg_dat = p;
        tick();
        cpu_ce = 1'b1;
        cpu_rw = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h05, 8'hFF, 15'h0123, 22'h14123, 22'h00123, 22'h28123};
        vecs[1] = '{8'h05, 8'hFF, 15'h4000, 22'h1C000, 22'h14000, 22'h2C000};
        vecs[2] = '{8'h07, 8'h06, 15'h4010, 22'h1C010, 22'h18010, 22'h34010};
        vecs[3] = '{8'h07, 8'h06, 15'h0010, 22'h1C010, 22'h00010, 22'h30010};
        vecs[4] = '{8'hFF, 8'h3C, 15'h3FFF, 22'h1FFFF, 22'h03FFF, 22'h63FFF};
        vecs[5] = '{8'hFF, 8'h3C, 15'h7FFF, 22'h1FFFF, 22'h33FFF, 22'h67FFF};
        vecs[6] = '{8'h00, 8'hFF, 15'h4ABC, 22'h1CABC, 22'h00ABC, 22'h04ABC};

        map_rst = 1'b1; cpu_addr = 15'h4000; cpu_dat = 8'h00; prg_dat = 8'hFF;
        cpu_ce = 1'b1; cpu_rw = 1'b1; ppu_addr = 14'h0000; cfg_mir_v = 1'b0;
        ss_act = 1'b0; ss_we = 1'b0; ss_addr = 8'd0;

        // Reset state
        #5;
        expect_val("rst_prg0", S0, 24'h0); expect_val("rst_prg1", S1, 24'h0);
        expect_val("rst_prg2", S2, 24'h0);
        expect_val("rst_map0", P0, 24'h1C000); expect_val("rst_map1", P1, 24'h0);
        expect_val("rst_map2", P2, 24'h04000);
        check_all();
        ss_addr = 8'd2;
        expect_val("rst_flags0", S0, 24'h0);
        check_all();
        tick(); tick();
        map_rst = 1'b0;

        // Table-driven PRG mapping across the three bank modes
        for (int i = 0; i < 7; i++) begin
            idle();
            cpu_write(vecs[i].dat, vecs[i].pdat);
            cpu_addr = vecs[i].raddr;
            expect_val($sformatf("vec%0d_u0", i), P0, 24'(vecs[i].e0));
            expect_val($sformatf("vec%0d_u1", i), P1, 24'(vecs[i].e1));
            expect_val($sformatf("vec%0d_u2", i), P2, 24'(vecs[i].e2));
            check_all();
        end

        // CHR banking and mirroring
        ppu_addr = 14'h0456; cfg_mir_v = 1'b1;
        idle();
        cpu_write(8'hA1, 8'hFF);
        expect_val("chr_u0", C0, 24'h04456); expect_val("mir_u0", A0, 24'h1);
        expect_val("chr_u1", C1, 24'h00456); expect_val("a10v_u1", A1, 24'h1);
        expect_val("chr_u2", C2, 24'h00456); expect_val("a10v_u2", A2, 24'h1);
        expect_val("cice_u0", E0, 24'h1);
        check_all();
        cfg_mir_v = 1'b0; ppu_addr = 14'h2456;
        expect_val("a10h_u2", A2, 24'h0); expect_val("cice_nt0", E0, 24'h0);
        expect_val("cice_nt1", E1, 24'h0); expect_val("cice_nt2", E2, 24'h0);
        expect_val("chr_nt_u0", C0, 24'h04456);
        check_all();
        idle();
        cpu_write(8'h30, 8'hFF);
        ppu_addr = 14'h1FFF;
        expect_val("chr3_u0", C0, 24'h07FFF); expect_val("mir0_u0", A0, 24'h0);
        expect_val("chr1_u2", C2, 24'h03FFF); expect_val("a10h1_u2", A2, 24'h1);
        check_all();

        // Back-to-back writes: filtered mappers keep the first
        idle();
        cpu_write(8'h03, 8'hFF);
        cpu_write(8'h05, 8'hFF);
        ss_addr = 8'd0;
        expect_val("rmw_u0", S0, 24'h03); expect_val("rmw_u1", S1, 24'h03);
        expect_val("rmw_u2", S2, 24'h05);
        check_all();
        ss_addr = 8'd2;
        expect_val("rmw_flags_u0", S0, 24'h02);
        check_all();
        idle();
        cpu_write(8'h01, 8'hFF);
        cpu_write(8'h02, 8'hFF);
        cpu_write(8'h06, 8'hFF);
        ss_addr = 8'd0;
        expect_val("rmw3_u0", S0, 24'h01); expect_val("rmw3_u1", S1, 24'h01);
        expect_val("rmw3_u2", S2, 24'h06);
        check_all();
        idle();
        cpu_write(8'h05, 8'hFF);
        expect_val("rmw_idle_u0", S0, 24'h05); expect_val("rmw_idle_u1", S1, 24'h05);
        expect_val("rmw_idle_u2", S2, 24'h05);
        check_all();

        // Save-state load blocks CPU writes
        idle();
        ss_act = 1'b1; ss_we = 1'b1; ss_addr = 8'd0; cpu_dat = 8'h04; cpu_ce = 1'b0; cpu_rw = 1'b0;
        tick();
        ss_we = 1'b0; cpu_dat = 8'h02;
        tick();
        expect_val("ss_prg_u0", S0, 24'h04); expect_val("ss_prg_u1", S1, 24'h04);
        expect_val("ss_prg_u2", S2, 24'h04);
        check_all();
        ss_addr = 8'd127;
        expect_val("ss_id_u0", S0, 24'd2); expect_val("ss_id_u1", S1, 24'd180);
        expect_val("ss_id_u2", S2, 24'd2);
        check_all();
        ss_addr = 8'd5;
        expect_val("ss_none_u0", S0, 24'hFF);
        check_all();
        ss_we = 1'b1; ss_addr = 8'd1; cpu_dat = 8'h01; cpu_ce = 1'b1; cpu_rw = 1'b1;
        tick();
        expect_val("ss_chr_u0", S0, 24'h01); expect_val("ss_chr_u1", S1, 24'h00);
        expect_val("ss_chr_u2", S2, 24'h01);
        check_all();
        ss_addr = 8'd2; cpu_dat = 8'h03;
        tick();
        ss_act = 1'b0; ss_we = 1'b0;
        cpu_write(8'h06, 8'hFF);
        ss_addr = 8'd0;
        expect_val("ss_filt_u0", S0, 24'h04); expect_val("ss_filt_u1", S1, 24'h04);
        expect_val("ss_filt_u2", S2, 24'h06);
        check_all();
        ss_addr = 8'd2;
        expect_val("ss_flags_u0", S0, 24'h03); expect_val("ss_flags_u1", S1, 24'h03);
        expect_val("ss_flags_u2", S2, 24'h03); expect_val("ss_mir_u0", A0, 24'h1);
        check_all();

        // Asynchronous reset mid-cycle, and a write under reset is lost
        idle();
        cpu_write(8'h05, 8'hFF);
        ss_addr = 8'd0;
        expect_val("pre_rst_u0", S0, 24'h05);
        check_all();
        @(posedge m2);
        #3;
        map_rst = 1'b1; cpu_addr = 15'h0123;
        expect_val("arst_u0", S0, 24'h0); expect_val("arst_u1", S1, 24'h0);
        expect_val("arst_u2", S2, 24'h0); expect_val("arst_map_u0", P0, 24'h00123);
        check_all();
        ss_addr = 8'd2;
        expect_val("arst_flags_u0", S0, 24'h0); expect_val("arst_flags_u1", S1, 24'h0);
        check_all();
        cpu_ce = 1'b0; cpu_rw = 1'b0; cpu_dat = 8'h07;
        tick();
        cpu_ce = 1'b1; cpu_rw = 1'b1; map_rst = 1'b0; ss_addr = 8'd0;
        expect_val("rst_wr_u0", S0, 24'h0); expect_val("rst_wr_u1", S1, 24'h0);
        expect_val("rst_wr_u2", S2, 24'h0);
        check_all();
        idle();
        cpu_write(8'h02, 8'hFF);
        expect_val("post_rst_u0", S0, 24'h02); expect_val("post_rst_u1", S1, 24'h02);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/map_uxrom_gen.md
MAP_UXROM_GEN -- requirements
Module: map_uxrom_gen

Interface
REQ-001 SHALL have parameter PRG_BITS, default 4: width of the PRG bank register, covering up to 2^PRG_BITS 16 KB banks (range 1..8).
REQ-002 SHALL have parameter CHR_BITS, default 0: width of the CHR bank register for 8 KB banks (range 0..4; 0 means no CHR banking).
REQ-003 SHALL have parameter CHR_SHIFT, default 4: bit position of the CHR field in the written data byte.
REQ-004 SHALL have parameter MODE, default 0: 0 = switchable bank at $8000 with last bank fixed at $C000; 1 = bank 0 fixed at $8000 with switchable bank at $C000; 2 = 32 KB switching.
REQ-005 SHALL have parameter BUS_CONF, default 1: 1 = the written value is ANDed with the ROM read data.
REQ-006 SHALL have parameter RMW_FILT, default 1: 1 = a write on the M2 cycle immediately after an accepted write is ignored.
REQ-007 SHALL have parameter MIR_BIT, default 8: data bit that selects single-screen page; 8 disables it and gives fixed hardware mirroring.
REQ-008 m2  in  1  clock; all state updates on the falling edge of m2.
REQ-009 map_rst  in  1  asynchronous, active-high reset.
REQ-010 cpu_addr  in  15  CPU address.
REQ-011 cpu_dat  in  8  CPU data bus.
REQ-012 prg_dat  in  8  ROM read data, used for bus conflict.
REQ-013 cpu_ce  in  1  active-low select of the $8000-$FFFF region.
REQ-014 cpu_rw  in  1  1 = read.
REQ-015 ppu_addr  in  14  PPU address.
REQ-016 cfg_mir_v  in  1  hardware mirroring: 1 = vertical.
REQ-017 ss_act  in  1  save-state access active.
REQ-018 ss_we  in  1  save-state write.
REQ-019 ss_addr  in  8  save-state index.
REQ-020 prg_addr  out  22  ROM address.
REQ-021 chr_addr  out  17  CHR address.
REQ-022 ciram_a10  out  1  CIRAM A10.
REQ-023 ciram_ce  out  1  CIRAM enable.
REQ-024 ss_rdat  out  8  save-state read data.

Function
REQ-025 A write SHALL be accepted on the m2 falling edge when cpu_ce=0, cpu_rw=0, ss_act=0 and the write is not filtered.
REQ-026 The effective data byte SHALL be cpu_dat & prg_dat when BUS_CONF=1, and cpu_dat otherwise.
REQ-027 On accept, prg SHALL load eff[PRG_BITS-1:0], chr SHALL load eff[CHR_SHIFT+CHR_BITS-1:CHR_SHIFT] when CHR_BITS>0, and mir SHALL load eff[MIR_BIT] when MIR_BIT<8.
REQ-028 A 1-bit flag wr_last SHALL be set by any CPU write cycle to $8000-$FFFF (filtered or not) and cleared by any other m2 cycle.
REQ-029 When RMW_FILT=1 and wr_last=1, the write SHALL be ignored, so the first of two back-to-back writes wins.
REQ-030 prg_addr[13:0] SHALL equal cpu_addr[13:0], and prg_addr[21:14] SHALL be zero-extended.
REQ-031 MODE 0: bank = cpu_addr[14] ? all-ones(PRG_BITS) : prg.
REQ-032 MODE 1: bank = cpu_addr[14] ? prg : 0.
REQ-033 MODE 2: bank = {prg, cpu_addr[14]}.
REQ-034 chr_addr SHALL equal {chr, ppu_addr[12:0]} zero-extended; chr is treated as 0 when CHR_BITS=0.
REQ-035 ciram_ce SHALL equal !ppu_addr[13].
REQ-036 ciram_a10 SHALL be mir when MIR_BIT<8; otherwise ppu_addr[10] if cfg_mir_v, else ppu_addr[11].
REQ-037 Save state, ss_act=1 and ss_we=1 at an m2 fall: index 0 loads prg, 1 loads chr, 2 loads {wr_last, mir} from cpu_dat[1:0]; CPU writes are blocked.
REQ-038 ss_rdat SHALL return index 0 = prg, 1 = chr, 2 = {6'b0, wr_last, mir}, 127 = 8'd180 when MODE=1 and 8'd2 otherwise, and 8'hFF for all other indices; all fields are zero-extended.
REQ-039 All output paths other than the registers SHALL be combinational, so the new bank is visible on the first access after the m2 fall of the write.

Reset
REQ-040 map_rst SHALL asynchronously clear prg, chr, mir and wr_last to 0, giving the reset bank map defined by MODE.
REQ-041 A reset asserted during a write cycle SHALL take priority; the write is lost.

Structure
REQ-042 Constants MODE_UNROM=0, MODE_180=1 and MODE_32K=2, and the save-state indices, SHALL live in the shared mapper defs package.
REQ-043 The block SHALL be a single module; an optional wrapper maps it to the standard map_out/bus buses.

Verification
REQ-044 MODE 0, PRG_BITS=3: write $05 to $8000 -> reading $8123 gives prg_addr=$14123, and reading $C000 gives $1C000.
REQ-045 MODE 1, BUS_CONF=1, prg_dat=$06: write $07 -> prg=6; reading $C010 gives $18010, and reading $8010 gives $00010.
REQ-046 RMW_FILT=1: write $03 then $05 on consecutive m2 cycles -> prg=3; after one idle cycle, writing $05 gives prg=5.
REQ-047 CHR_BITS=2, CHR_SHIFT=4, MIR_BIT=7: write $A1 -> chr=2, mir=1, chr_addr for ppu $0456 = $04456, and ciram_a10=1.
REQ-048 Save state: ss write of index 0 = $04 with ss_act=1 while a CPU write of $02 is attempted -> prg=4; ss_rdat at index 127 = 180 in MODE 1.
REQ-049 Reset: assert map_rst mid-cycle after prg=5 -> prg=0 immediately and wr_last=0, without waiting for an m2 edge.
